insn_decoder: RTL
=================

# insn_decoder

Instruction decode stage directly downstream of the instruction fetcher. It consumes the fetched instruction word and its valid/stall handshake. It splits the word into registered operand fields, flags undefined opcodes, and optionally expands a repeat count into back-to-back issues of the same instruction. It exposes the same valid/stall pipeline protocol to the execute stage.

## Interface
- `LEN_INSN`, 32, instruction word width; field layout below assumes 32.
- `NUM_OPCODES`, 48, opcodes `0..NUM_OPCODES-1` are legal.
- `clk`  input  1  clock; all state updates on posedge.
- `rst`  input  1  reset, asynchronous, active-low.
- `valid_i`  input  1  upstream word on `insn_i` is valid.
- `insn_i`  input  LEN_INSN  instruction word from fetcher (stable while `stall_o` high).
- `stall_o`  output  1  upstream must hold its word and valid.
- `valid_o`  output  1  decoded outputs are valid.
- `stall_i`  input  1  downstream cannot accept this cycle.
- `opcode_o`  output  6  `insn[31:26]`.
- `rd_o`, `rs_o`, `rt_o`  output  5 each  `insn[25:21]`, `insn[20:16]`, `insn[15:11]`.
- `imm_o`  output  32  `insn[15:0]` sign-extended.
- `iter_o`  output  3  issue index within a repeat group (0 = first issue).
- `illegal_o`  output  1  `opcode_o >= NUM_OPCODES`; qualified by `valid_o`.

## Operation
- Output register holds one decoded instruction. A 3-bit counter `cnt` holds remaining extra issues; `busy = (cnt != 0)`.
- `hold = valid_o & stall_i`; `stall_o = hold | busy` (combinational).
- Load (`ld = ~hold & ~busy`) at posedge:
  - `valid_o <= valid_i`.
  - Fields and `illegal_o` are captured from `insn_i`; `iter_o <= 0`.
  - `cnt <= (valid_i & legal) ? insn_i[10:8] : 0`.
- Repeat step (`~hold & busy`): `cnt <= cnt-1`, `iter_o <= iter_o+1`. `valid_o` stays 1 and all fields are unchanged.
- `hold`: all state is frozen.
- A repeat field of N gives N+1 consecutive issues with `iter_o` = 0..N.
- An illegal opcode issues exactly once, with `illegal_o=1`; its repeat field is ignored.
- When `valid_i=0` on a load, the fields capture `insn_i` anyway (don't-care) and `illegal_o` is forced 0.
- State machine: IDLE (`valid_o=0`), ISSUE (`valid_o=1`, `cnt=0`), REPEAT (`valid_o=1`, `cnt>0`).
  - IDLE→ISSUE/REPEAT on load with `valid_i`.
  - REPEAT→ISSUE when `cnt` steps to 0.
  - ISSUE→IDLE on load with `valid_i=0`.
  - ISSUE→ISSUE/REPEAT on load with `valid_i=1`.

## Timing
- Reset (`rst` low, asynchronous): `valid_o=0`, `illegal_o=0`, `cnt=0`, `iter_o=0`, all fields 0. Therefore `stall_o=0`.
- Latency: a word accepted at edge k appears on the outputs after edge k; one cycle.
- Throughput: one instruction per cycle with no stall and no repeat.
- Repeat N blocks upstream for N cycles: `stall_o` stays high while `busy`.
- `stall_i` is asserted during REPEAT: `cnt` and `iter_o` freeze. The current issue is held until `stall_i` drops.
- `stall_i` high with `valid_o=0`: no stall propagates (`stall_o=0`, bubble is overwritten).
- Reset mid-repeat: the group is abandoned; outputs return to their reset values immediately.

## Configuration
- `INSN_DECODER_REPEAT_EN` defined: repeat expansion is active as above.
- `INSN_DECODER_REPEAT_EN` undefined:
  - `cnt` is removed and `busy` is constant 0.
  - `stall_o = valid_o & stall_i`.
  - Every instruction issues once, and `iter_o` is tied to 0.
  - `insn[10:8]` is ignored.

## Test plan
- Reset then stream words with opcodes 1, 2, 3, repeat 0, `stall_i=0` → outputs 1, 2, 3 one cycle after each is presented; `stall_o` never high.
- `insn_i` with opcode 5, `rd=3`, `imm=16'hFFF0`, repeat 0 → `opcode_o=5`, `rd_o=3`, `imm_o=32'hFFFF_FFF0`, `iter_o=0`.
- Opcode 7, repeat 3 (repeat enabled) → 4 valid cycles with `iter_o` 0, 1, 2, 3. `stall_o` is high for exactly 3 cycles, then the next word is loaded.
- Repeat 2 with `stall_i` high for 2 cycles during `iter_o=1` → `iter_o=1` held 3 cycles total, then 2. No duplicate or lost issue.
- Opcode 50, repeat 5 → a single issue with `illegal_o=1`; `stall_o` stays 0 absent `stall_i`.
- Assert `rst` low mid-repeat (`iter_o=1`) → `valid_o` and `stall_o` drop to 0 without a clock edge. After release, the next word decodes normally.

Source files
------------

// File: rtl/insn_decoder_if.sv
// Handshake and decoded-field bundle between fetch, decode and execute.
// The "slave" modport is the decoder's view: it receives the fetched word
// and the downstream stall, and drives the decoded fields and the upstream
// stall. The "master" modport is the surrounding pipeline's view.
interface insn_decoder_if #(
  parameter int LEN_INSN = 32
);

  // Fetch -> decode
  logic                valid_i;
  logic [LEN_INSN-1:0] insn_i;
  logic                stall_o;

  // Decode -> execute
  logic                valid_o;
  logic                stall_i;
  logic [5:0]          opcode_o;
  logic [4:0]          rd_o;
  logic [4:0]          rs_o;
  logic [4:0]          rt_o;
  logic [31:0]         imm_o;
  logic [2:0]          iter_o;
  logic                illegal_o;

  modport master (
    output valid_i, insn_i, stall_i,
    input  stall_o, valid_o, opcode_o, rd_o, rs_o, rt_o, imm_o, iter_o,
           illegal_o
  );

  modport slave (
    input  valid_i, insn_i, stall_i,
    output stall_o, valid_o, opcode_o, rd_o, rs_o, rt_o, imm_o, iter_o,
           illegal_o
  );

endinterface

// File: rtl/insn_decoder.sv
// Instruction decode stage.
// Splits the fetched word into registered operand fields, flags opcodes at
// or above NUM_OPCODES as illegal, and forwards a valid/stall handshake to
// the execute stage with one cycle of latency.
//
// Build option INSN_DECODER_REPEAT_EN: when defined, insn[10:8] of a legal
// word is a repeat count N and the instruction is issued N+1 times back to
// back with iter_o = 0..N while upstream is stalled. When undefined, every
// word issues once, iter_o is tied to 0 and insn[10:8] is only part of imm.
module insn_decoder #(
  parameter int LEN_INSN    = 32,
  parameter int NUM_OPCODES = 48
) (
  input  logic          clk,
  input  logic          rst,
  insn_decoder_if.slave bus
);

  // IDLE: no valid output. ISSUE: valid, no further repeats pending.
  // REPEAT: valid, at least one more issue of the same word pending.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Everything that is captured from the word on a load.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic        illegal;
  } fields_t;

  // Opcode is 6 bits; one extra bit lets NUM_OPCODES up to 64 compare cleanly.
  localparam logic [6:0] NUM_OPC = 7'(NUM_OPCODES);

  logic [LEN_INSN-1:0] insn;
  logic                legal;
  fields_t             dec;
  fields_t             fields_q;
  fields_t             fields_d;
  state_t              state_q;
  state_t              state_d;
  logic                valid_q;
  logic                hold;
  logic                busy;
  logic                ld;

  assign insn  = bus.insn_i;
  assign legal = ({1'b0, insn[31:26]} < NUM_OPC);

  // Field split of the incoming word. A bubble (valid_i low) still carries
  // the raw fields, but never reports an illegal opcode.
  assign dec.opcode  = insn[31:26];
  assign dec.rd      = insn[25:21];
  assign dec.rs      = insn[20:16];
  assign dec.rt      = insn[15:11];
  assign dec.imm     = {{16{insn[15]}}, insn[15:0]};
  assign dec.illegal = bus.valid_i & ~legal;

  assign valid_q = (state_q != IDLE);

  // Downstream back-pressure only matters when we actually hold something;
  // a stalled bubble is simply overwritten.
  assign hold = valid_q & bus.stall_i;
  assign ld   = ~hold & ~busy;

`ifdef INSN_DECODER_REPEAT_EN
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic [2:0] iter_q;
  logic [2:0] iter_d;
  logic [2:0] rep;
  logic       step;

  // Illegal words and bubbles never repeat, whatever their [10:8] holds.
  assign rep  = (bus.valid_i & legal) ? insn[10:8] : 3'd0;
  assign busy = (cnt_q != 3'd0);
  assign step = ~hold & busy;
`else
  assign busy = 1'b0;
`endif

  // Next-state and next-datapath selection: load, repeat step, or freeze.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d  = state_q;
    fields_d = fields_q;
`ifdef INSN_DECODER_REPEAT_EN
    cnt_d    = cnt_q;
    iter_d   = iter_q;
`endif

    if (ld) begin
      fields_d = dec;
      state_d  = bus.valid_i ? ISSUE : IDLE;
`ifdef INSN_DECODER_REPEAT_EN
      cnt_d    = rep;
      iter_d   = 3'd0;
      if (rep != 3'd0) begin
        state_d = REPEAT;
      end
`endif
    end

`ifdef INSN_DECODER_REPEAT_EN
    // ld and step are mutually exclusive: step needs busy, ld needs ~busy.
    if (step) begin
      cnt_d   = cnt_q - 3'd1;
      iter_d  = iter_q + 3'd1;
      state_d = (cnt_q == 3'd1) ? ISSUE : REPEAT;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Decoded-field register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the field register is wide but is still reset, because execute
    // expects all-zero fields (and illegal_o low) straight out of reset.
    if (!rst) begin
      fields_q <= '0;
    end else begin
      fields_q <= fields_d;
    end
  end

`ifdef INSN_DECODER_REPEAT_EN
  // Repeat counter and issue index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= 3'd0;
      iter_q <= 3'd0;
    end else begin
      cnt_q  <= cnt_d;
      iter_q <= iter_d;
    end
  end

  assign bus.iter_o = iter_q;
`else
  assign bus.iter_o = 3'd0;
`endif

  assign bus.stall_o   = hold | busy;
  assign bus.valid_o   = valid_q;
  assign bus.opcode_o  = fields_q.opcode;
  assign bus.rd_o      = fields_q.rd;
  assign bus.rs_o      = fields_q.rs;
  assign bus.rt_o      = fields_q.rt;
  assign bus.imm_o     = fields_q.imm;
  assign bus.illegal_o = fields_q.illegal;

endmodule
